// File: rtl/if_fetch_if.sv
// Byte-wide memory-controller port shared by the fetch stage: request/address
// out, grant and read data back.
interface if_fetch_if #(
  parameter int ADDR_W = 32
) ();
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic [7:0]        mem_din;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_gnt,
    input  mem_din
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_gnt,
    output mem_din
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a little-endian 32-bit instruction from four
// byte reads and holds the PC via stall_req until decode takes it.
module if_fetch #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  input  logic              jump_flag,
  input  logic              id_stall,
  if_fetch_if.master        mem,
  output logic              if_valid,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              stall_req
);

  typedef enum logic [0:0] {FETCH = 1'b0, DONE = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [2:0]        req_cnt_q, req_cnt_d;
  logic [2:0]        rsp_cnt_q, rsp_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic              fetch_req;
  logic              accept;

  // Next-state, request generation and byte assembly
  always_comb begin
    state_d    = state_q;
    req_cnt_d  = req_cnt_q;
    rsp_cnt_d  = rsp_cnt_q;
    rd_pend_d  = 1'b0;
    rd_idx_d   = rd_idx_q;
    if_valid_d = if_valid_q;
    if_inst_d  = if_inst_q;
    if_pc_d    = if_pc_q;
    fetch_req  = 1'b0;
    accept     = if_valid_q & ~id_stall;

    if (!jump_flag) begin
      case (state_q)
        FETCH: begin
          fetch_req = rst_n & (req_cnt_q < 3'd4);
          if (fetch_req && mem.mem_gnt) begin
            req_cnt_d = req_cnt_q + 3'd1;
            rd_pend_d = 1'b1;
            rd_idx_d  = req_cnt_q[1:0];
          end else begin
            rd_pend_d = 1'b0;
          end
          if (rd_pend_q) begin
            case (rd_idx_q)
              2'd0:    if_inst_d[7:0]   = mem.mem_din;
              2'd1:    if_inst_d[15:8]  = mem.mem_din;
              2'd2:    if_inst_d[23:16] = mem.mem_din;
              2'd3:    if_inst_d[31:24] = mem.mem_din;
              default: if_inst_d        = if_inst_q;
            endcase
            rsp_cnt_d = rsp_cnt_q + 3'd1;
            // The fourth response completes the instruction
            if (rsp_cnt_q == 3'd3) begin
              state_d    = DONE;
              if_valid_d = 1'b1;
              if_pc_d    = pc;
            end else begin
              state_d = FETCH;
            end
          end else begin
            rsp_cnt_d = rsp_cnt_q;
          end
        end
        DONE: begin
          if (accept) begin
            if_valid_d = 1'b0;
            req_cnt_d  = 3'd0;
            rsp_cnt_d  = 3'd0;
            state_d    = FETCH;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end else begin
      // Redirect drops any in-flight byte and any held instruction
      state_d    = FETCH;
      req_cnt_d  = 3'd0;
      rsp_cnt_d  = 3'd0;
      rd_pend_d  = 1'b0;
      if_valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      req_cnt_q  <= 3'd0;
      rsp_cnt_q  <= 3'd0;
      rd_pend_q  <= 1'b0;
      rd_idx_q   <= 2'd0;
      if_valid_q <= 1'b0;
      if_inst_q  <= 32'd0;
      if_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_cnt_q  <= req_cnt_d;
      rsp_cnt_q  <= rsp_cnt_d;
      rd_pend_q  <= rd_pend_d;
      rd_idx_q   <= rd_idx_d;
      if_valid_q <= if_valid_d;
      if_inst_q  <= if_inst_d;
      if_pc_q    <= if_pc_d;
    end
  end

  assign mem.mem_req  = fetch_req;
  assign mem.mem_addr = pc + ADDR_W'(req_cnt_q);
  assign stall_req    = ~((state_q == DONE) & ~id_stall);
  assign if_valid     = if_valid_q;
  assign if_inst      = if_inst_q;
  assign if_pc        = if_pc_q;

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage for the toy RISC-V core. It consumes the program counter driven by the PC register and reads the 32-bit instruction at that address as four byte reads over the shared byte-wide memory-controller port. It presents the assembled instruction and its PC to the decode stage. While a fetch is incomplete it drives a stall request back toward the PC register, so the PC holds until the instruction has been handed downstream.

## Interface
- ADDR_W, 32, width of PC and memory address
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- pc  in  ADDR_W  current PC from PC register; stable while stall_req is high
- jump_flag  in  1  redirect; PC register loads the branch target at this edge
- id_stall  in  1  decode stage cannot accept an instruction this cycle
- mem_req  out  1  byte read request
- mem_addr  out  ADDR_W  byte address of request
- mem_gnt  in  1  memory controller accepts mem_req this cycle
- mem_din  in  8  read byte, valid exactly one cycle after a granted request
- if_valid  out  1  if_inst/if_pc hold a complete instruction
- if_inst  out  32  assembled instruction, little-endian
- if_pc  out  ADDR_W  address of if_inst
- stall_req  out  1  hold PC (feeds stall_signal[0])

## Operation
- States: FETCH, DONE. Counters req_cnt, rsp_cnt (3 bits, 0..4). Response tracking: rd_pend flag plus 2-bit rd_idx.
- FETCH:
  - mem_req = rst_n & !jump_flag & (req_cnt < 4); mem_addr = pc + req_cnt (ADDR_W wrap, no carry out).
  - On an edge where mem_req & mem_gnt: req_cnt++, rd_pend <= 1, rd_idx <= req_cnt.
  - Otherwise rd_pend <= 0.
  - Without a grant, mem_req and mem_addr hold unchanged.
  - Each cycle with rd_pend = 1: mem_din is written into byte lane rd_idx (bits 8k+7:8k) and rsp_cnt is incremented.
  - When byte 3 is captured: if_inst is written, if_pc <= pc, if_valid <= 1, state <= DONE.
- DONE:
  - mem_req = 0.
  - Accept = if_valid & !id_stall. On accept: if_valid <= 0, counters cleared, state <= FETCH.
- stall_req = !(state==DONE & !id_stall), combinational. It is high in FETCH, and high in DONE while id_stall is high.
- jump_flag (dominates everything), on that edge:
  - state <= FETCH, req_cnt/rsp_cnt <= 0, if_valid <= 0, rd_pend <= 0.
  - A byte that arrives in the following cycle is discarded.
  - The new fetch starts the next cycle using the redirected pc.
- If jump_flag and accept coincide in DONE, the instruction is dropped (if_valid falls). The PC register takes the jump target.
- Reset (asynchronous, immediate, independent of clk):
  - state FETCH, counters 0, rd_pend 0, if_valid 0, if_inst 0, if_pc 0.
  - mem_req 0 while rst_n is low; stall_req 1.

## Timing
- Continuous grant: fetch starts in cycle 0.
  - Grants in cycles 0-3; bytes arrive in cycles 1-4.
  - if_valid rises in cycle 5, and stall_req falls in that same cycle if id_stall is low.
  - PC advances at the end of cycle 5. The next fetch starts in cycle 6, giving 1 instruction per 6 cycles.
- Each cycle with mem_gnt low during FETCH adds exactly one cycle of latency.
- if_valid, if_inst and if_pc are registered. They stay stable while if_valid & id_stall.
- mem_req, mem_addr and stall_req are combinational from state/counters/pc/jump_flag/id_stall.
- At most one response is outstanding at a time. Four requests and four responses are completed per instruction.

## Test plan
- Reset, pc=0x0, memory bytes 0x13,0x05,0x10,0x00, mem_gnt=1:
  - mem_addr 0x0..0x3 in cycles 0-3.
  - In cycle 5: if_valid=1, if_inst=0x00100513, if_pc=0x0, stall_req=0.
  - Next fetch issues 0x4.
- mem_gnt low for 2 cycles after byte 1 is granted:
  - mem_addr holds pc+2 during the gap and mem_req stays high.
  - if_valid rises in cycle 7 with the correct instruction.
- id_stall=1 for 3 cycles while in DONE:
  - if_valid, if_inst and if_pc stay stable, stall_req=1, mem_req=0.
  - Accept happens in the cycle id_stall falls.
- jump_flag after 2 grants, with pc becoming 0x100:
  - The byte arriving after the jump is discarded.
  - Next requests go to 0x100..0x103.
  - if_pc=0x100 with bytes from the new address only.
- jump_flag in DONE with id_stall=1: if_valid=0 on the next cycle, and the fetch restarts at the new pc.
- rst_n driven low mid-fetch between clock edges: if_valid, if_inst, if_pc and mem_req go to 0 immediately. After release, the fetch restarts with req_cnt=0.
